if_id_stage: RTL

//   Fetch stage plus IF/ID pipeline register, directly upstream of the hazard detection unit.

---
 rtl/if_id_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//   Instruction fetch stage plus the IF/ID pipeline register. It owns the PC,
//   presents it as the instruction-memory address and captures the returned
//   instruction together with its PC+4 into IF/ID. Hold and flush controls
//   come from the hazard detection unit. Two saturating counters record the
//   stall cycles and the flush bubbles for performance debug.
// -----------------------------------------------------------------------------
module if_id_stage #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = {PC_WIDTH{1'b0}},
  parameter int unsigned          CNT_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    Hold_PC_i,
  input  logic                    Hold_IfId_i,
  input  logic                    Flush_i,
  input  logic                    Jump_i,
  input  logic                    Branch_Equal_i,
  input  logic [PC_WIDTH-1:0]     JumpTarget_i,
  input  logic [PC_WIDTH-1:0]     BranchTarget_i,
  input  logic [INSTR_WIDTH-1:0]  Instr_i,
  output logic [PC_WIDTH-1:0]     PC_o,
  output logic [PC_WIDTH-1:0]     IfId_PC4_o,
  output logic [INSTR_WIDTH-1:0]  IfId_Instr_o,
  output logic                    IfId_Valid_o,
  output logic [CNT_WIDTH-1:0]    StallCount_o,
  output logic [CNT_WIDTH-1:0]    FlushCount_o
);

  // Sequential fetch step; built by concatenation so it stays width-exact
  // for any PC_WIDTH of 3 or more.
  localparam logic [PC_WIDTH-1:0]    PC_STEP  = {{(PC_WIDTH-3){1'b0}}, 3'b100};
  localparam logic [PC_WIDTH-1:0]    PC_ZERO  = {PC_WIDTH{1'b0}};
  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = {INSTR_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = {CNT_WIDTH{1'b1}};

  // PC + 4, wrapping modulo 2^PC_WIDTH (carry out is simply dropped).
  function automatic logic [PC_WIDTH-1:0] pc_plus4(input logic [PC_WIDTH-1:0] pc);
    pc_plus4 = pc + PC_STEP;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + CNT_ONE;
    end
  endfunction

  // Architectural state
  logic [PC_WIDTH-1:0]    pc_q,          pc_d;
  logic [PC_WIDTH-1:0]    ifid_pc4_q,    ifid_pc4_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q,  ifid_instr_d;
  logic                   ifid_valid_q,  ifid_valid_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q,   stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q,   flush_cnt_d;

  // Combinational view of the sequential successor of the current PC; it is
  // both the default next PC and the PC+4 recorded alongside the instruction.
  logic [PC_WIDTH-1:0]    pc_seq_s;
  // A flush only becomes a bubble when IF/ID is not being held.
  logic                   flush_take_s;

  assign pc_seq_s     = pc_plus4(pc_q);
  assign flush_take_s = Flush_i & ~Hold_IfId_i;

  // Next PC: hold beats jump, jump beats taken branch, else sequential.
  always_comb begin
    pc_d = pc_q;
    if (Hold_PC_i) begin
      pc_d = pc_q;
    end else if (Jump_i) begin
      pc_d = JumpTarget_i;
    end else if (Branch_Equal_i) begin
      pc_d = BranchTarget_i;
    end else begin
      pc_d = pc_seq_s;
    end
  end

  // Next IF/ID contents: hold freezes everything, flush inserts a NOP bubble,
  // otherwise capture the instruction currently returned by memory.
  always_comb begin
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (Hold_IfId_i) begin
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
    end else if (Flush_i) begin
      ifid_pc4_d   = PC_ZERO;
      ifid_instr_d = INSTR_NOP;
      ifid_valid_d = 1'b0;
    end else begin
      ifid_pc4_d   = pc_seq_s;
      ifid_instr_d = Instr_i;
      ifid_valid_d = 1'b1;
    end
  end

  // Next performance counter values: saturating event counts.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Hold_PC_i) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_take_s) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // PC register; reset restarts fetch at RESET_PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID pipeline register; reset leaves a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_pc4_q   <= PC_ZERO;
      ifid_instr_q <= INSTR_NOP;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Performance counters; cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= CNT_ZERO;
      flush_cnt_q <= CNT_ZERO;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC_o         = pc_q;
  assign IfId_PC4_o   = ifid_pc4_q;
  assign IfId_Instr_o = ifid_instr_q;
  assign IfId_Valid_o = ifid_valid_q;
  assign StallCount_o = stall_cnt_q;
  assign FlushCount_o = flush_cnt_q;

endmodule
